// File: rtl/sb_tile_param.sv
// Parametrised 4-side switch-box tile with double-buffered routing config and readback.
// Define SB_TILE_OUT_REG_EN to add a selectable per-output pipeline register.
module sb_tile_param #(
    parameter int NUM_TRACKS = 4,
    parameter int TRACK_W    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            config_en,
    input  logic [31:0]                     config_addr,
    input  logic [31:0]                     config_data,
    input  logic [15:0]                     tile_id,
    output logic [31:0]                     config_rd_data,
    input  logic [4*NUM_TRACKS*TRACK_W-1:0] track_in,
    output logic [4*NUM_TRACKS*TRACK_W-1:0] track_out
);
    localparam int NW = 4 * NUM_TRACKS;
    localparam int IW = $clog2(NW);
    localparam int BW = NW * TRACK_W;

    logic [NW-1:0][3:0] shadow_q, shadow_d;
    logic [NW-1:0][3:0] active_q, active_d;
    logic [31:0]        rd_q, rd_d;
    logic [15:0]        addr_tile;
    logic [15:0]        addr_idx;
    logic [IW-1:0]      idx;
    logic               id_match;
    logic               bcast;
    logic               hit;
    logic               in_range;
    logic               commit;
    logic [BW-1:0]      mux_val;
    logic               unused_data;

    assign addr_tile   = config_addr[31:16];
    assign addr_idx    = config_addr[15:0];
    assign idx         = addr_idx[IW-1:0];
    assign id_match    = addr_tile == tile_id;
    assign bcast       = addr_tile == 16'hFFFF;
    assign hit         = config_en && (id_match || bcast);
    assign in_range    = 32'(addr_idx) < 32'(NW);
    assign commit      = hit && (addr_idx == 16'hFFFF);
    assign unused_data = ^config_data[31:4];

    // Commit copies the pre-edge shadow, so a write in an earlier cycle is seen.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        rd_d     = '0;
        if (hit && in_range) begin
            shadow_d[idx] = config_data[3:0];
        end
        if (commit) begin
            active_d = shadow_q;
        end
        if (id_match && !bcast && in_range) begin
            rd_d = {28'b0, shadow_q[idx]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            active_q <= '0;
            rd_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            rd_q     <= rd_d;
        end
    end

    assign config_rd_data = rd_q;

    function automatic logic [TRACK_W-1:0] route(
        input logic          en,
        input logic [1:0]    sel,
        input int            s,
        input int            t,
        input logic [BW-1:0] tin
    );
        int src;
        src   = int'(sel);
        route = '0;
        if (en && src != s) begin
            route = tin[(src*NUM_TRACKS+t)*TRACK_W +: TRACK_W];
        end
    endfunction

    always_comb begin
        mux_val = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                mux_val[(s*NUM_TRACKS+t)*TRACK_W +: TRACK_W] = route(
                    active_q[s*NUM_TRACKS+t][3],
                    active_q[s*NUM_TRACKS+t][1:0],
                    s, t, track_in);
            end
        end
    end

`ifdef SB_TILE_OUT_REG_EN
    logic [BW-1:0] pipe_q, pipe_d;

    // Flops load every edge; bit 2 only picks which copy reaches the pin.
    assign pipe_d = mux_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    always_comb begin
        track_out = mux_val;
        for (int i = 0; i < NW; i++) begin
            if (active_q[i][2]) begin
                track_out[i*TRACK_W +: TRACK_W] = pipe_q[i*TRACK_W +: TRACK_W];
            end
        end
    end
`else
    logic unused_pipe_bits;

    always_comb begin
        unused_pipe_bits = 1'b0;
        for (int i = 0; i < NW; i++) begin
            unused_pipe_bits = unused_pipe_bits ^ active_q[i][2];
        end
    end

    assign track_out = mux_val;
`endif

endmodule

// File: tb/tb_sb_tile_param.sv
// Directed bench for sb_tile_param (NUM_TRACKS=4, TRACK_W=1, tile_id=5).
// Bit s*4+t of track_in/track_out is side s, track t.
module tb_sb_tile_param;
    logic        clk;
    logic        rst;
    logic        config_en;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic [15:0] tile_id;
    logic [31:0] config_rd_data;
    logic [15:0] track_in;
    logic [15:0] track_out;

    int total;
    int bad;

    typedef struct {
        logic [15:0] tin;
        logic [15:0] tout;
    } vec_t;

    vec_t vecs [10];

    sb_tile_param #(
        .NUM_TRACKS(4),
        .TRACK_W   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .config_en     (config_en),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .tile_id       (tile_id),
        .config_rd_data(config_rd_data),
        .track_in      (track_in),
        .track_out     (track_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cfg(input logic [31:0] a, input logic [31:0] d);
        config_en   = 1'b1;
        config_addr = a;
        config_data = d;
        @(posedge clk);
        #1;
        config_en = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [31:0] a,
                         input logic [31:0] exp);
        config_en   = 1'b0;
        config_addr = a;
        @(posedge clk);
        #1;
        check(nm, config_rd_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        config_en   = 1'b0;
        config_addr = '0;
        config_data = '0;
        tile_id     = 16'd5;
        track_in    = 16'($urandom);

        vecs[0] = '{16'h0000, 16'h0000};
        vecs[1] = '{16'hFFFF, 16'h1423};
        vecs[2] = '{16'h0010, 16'h1001};
        vecs[3] = '{16'h0200, 16'h0002};
        vecs[4] = '{16'h0002, 16'h0020};
        vecs[5] = '{16'h4000, 16'h0400};
        vecs[6] = '{16'h5A5A, 16'h1423};
        vecs[7] = '{16'h0012, 16'h1021};
        vecs[8] = '{16'h8000, 16'h0000};
        vecs[9] = '{16'h0040, 16'h0000};

        // reset
        #2;
        check("rst_out", 32'(track_out), 0);
        check("rst_rd", config_rd_data, 0);
        @(posedge clk);
        #1;
        track_in = 16'hFFFF;
        #1;
        check("rst_out_ones", 32'(track_out), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_out", 32'(track_out), 0);

        // shadow write, readback, commit
        track_in = 16'h0010;
        cfg(32'h0005_0000, 32'h9);
        check("shadow_only", 32'(track_out), 0);
        @(posedge clk);
        #1;
        check("rd_idx0", config_rd_data, 32'h9);
        config_en   = 1'b1;
        config_addr = 32'h0005_FFFF;
        #1;
        check("pre_commit", 32'(track_out), 0);
        @(posedge clk);
        #1;
        config_en = 1'b0;
        check("post_commit", 32'(track_out), 32'h0001);
        check("rd_commit_idx", config_rd_data, 0);

        // same-cycle write and read returns the old word
        cfg(32'h0005_0002, 32'h3);
        check("rd_old_val", config_rd_data, 0);
        @(posedge clk);
        #1;
        check("rd_new_val", config_rd_data, 32'h3);

        // broadcast and miss
        track_in = 16'h0200;
        cfg(32'hFFFF_0001, 32'hA);
        cfg(32'hFFFF_FFFF, 32'h0);
        check("bcast_route", 32'(track_out), 32'h0002);
        cfg(32'h0006_0001, 32'h0);
        cfg(32'h0006_FFFF, 32'h0);
        check("miss_commit", 32'(track_out), 32'h0002);
        cfg(32'h0005_FFFF, 32'h0);
        check("miss_no_write", 32'(track_out), 32'h0002);

        rdchk("rd_oor_40", 32'h0005_0040, 0);
        rdchk("rd_bcast_id", 32'hFFFF_0000, 0);
        rdchk("rd_other_id", 32'h0006_0000, 0);
        rdchk("rd_bcast_wr", 32'h0005_0001, 32'hA);

        // route table
        cfg(32'h0005_0005, 32'h8);
        cfg(32'h0005_000A, 32'hB);
        cfg(32'h0005_000F, 32'hF);
        cfg(32'h0005_0004, 32'h0);
        cfg(32'h0005_0006, 32'h1);
        cfg(32'h0005_000C, 32'h9);
        cfg(32'h0005_FFFF, 32'h0);
        rdchk("rd_idx15", 32'h0005_000F, 32'hF);
        rdchk("rd_idx16", 32'h0005_0010, 0);

        for (int i = 0; i < 10; i++) begin
            track_in = vecs[i].tin;
            #1;
            check($sformatf("vec%0d", i), 32'(track_out), 32'(vecs[i].tout));
        end

        // reset mid-packet
        track_in    = 16'hFFFF;
        config_en   = 1'b1;
        config_addr = 32'h0005_0000;
        config_data = 32'h0;
        #1;
        check("pre_rst_out", 32'(track_out), 32'h1423);
        rst = 1'b0;
        #1;
        check("async_rst_out", 32'(track_out), 0);
        check("async_rst_rd", config_rd_data, 0);
        config_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdchk("rst_shadow_clr", 32'h0005_0000, 0);
        check("rst_active_clr", 32'(track_out), 0);

`ifdef SB_TILE_OUT_REG_EN
        track_in = 16'h0010;
        cfg(32'h0005_0000, 32'hD);
        cfg(32'h0005_FFFF, 32'h0);
        check("reg_commit_edge", 32'(track_out), 0);
        @(posedge clk);
        #1;
        check("reg_one_cyc", 32'(track_out), 32'h0001);
        track_in = 16'h0000;
        #1;
        check("reg_hold", 32'(track_out), 32'h0001);
        @(posedge clk);
        #1;
        check("reg_fall", 32'(track_out), 0);
        track_in = 16'h0010;
        #1;
        check("reg_no_comb", 32'(track_out), 0);
        @(posedge clk);
        #1;
        check("reg_rise", 32'(track_out), 32'h0001);
        cfg(32'h0005_0000, 32'h9);
        cfg(32'h0005_FFFF, 32'h0);
        check("comb_again", 32'(track_out), 32'h0001);
        track_in = 16'h0000;
        #1;
        check("comb_zero_dly", 32'(track_out), 0);
        cfg(32'h0005_0000, 32'hD);
        cfg(32'h0005_FFFF, 32'h0);
        track_in = 16'h0010;
        @(posedge clk);
        #1;
        check("reg_pre_rst", 32'(track_out), 32'h0001);
        rst = 1'b0;
        #1;
        check("reg_async_rst", 32'(track_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
